wb_fb_fill_arbiter: RTL and testbench
=====================================

# wb_fb_fill_arbiter

Sits between the CPU Wishbone bus and the 160x120 RGB332 framebuffer's Wishbone write port. It shares that single write port between two requesters: direct CPU pixel writes, and a built-in rectangle-fill engine that the CPU programs through a small register window. CPU traffic has fixed priority. The fill engine drains whole rectangles one pixel at a time with row-major addressing (y*160+x).

## Interface
Parameters:
- FB_WIDTH, 160, framebuffer width in pixels
- FB_HEIGHT, 120, framebuffer height in pixels

Ports:
- I_wb_clk  in  1  sole clock; all logic
- I_rst_n  in  1  asynchronous, active-low reset
- I_wb_adr  in  16  bit15=0: pixel address [14:0]; bit15=1: register window, offset [2:0]
- I_wb_dat  in  8  CPU write data
- I_wb_we, I_wb_stb, I_wb_cyc  in  1 each  CPU cycle qualifiers
- O_wb_ack  out  1  CPU ack, one-cycle pulse
- O_wb_dat  out  8  CPU read data
- O_fb_adr  out  15  framebuffer pixel address
- O_fb_dat  out  8  framebuffer write data
- O_fb_we, O_fb_stb, O_fb_cyc  out  1 each  master qualifiers (we=cyc=stb)
- I_fb_ack  in  1  framebuffer ack
- O_irq  out  1  one-cycle pulse on fill completion

## Operation
Register window (adr[15]=1):
- 0 X0: start x
- 1 Y0: start y
- 2 W: width
- 3 H: height
- 4 COLOR: fill value
- 5 CTRL
  - Write: bit0=1 starts a fill; bit1=1 clears DONE.
  - Read: bit0 BUSY, bit1 DONE (sticky).
- 6, 7 read 0. Writes to them are ignored.
- Register writes other than CTRL are accepted while BUSY. They do not affect the fill in progress.

CPU requests:
- A request is valid when stb&&cyc && !O_wb_ack.
- Register read/write: ack next cycle, with no master transaction.
- Pixel read: ack next cycle, O_wb_dat=0.
- Pixel write: queued as a CPU master request. O_wb_ack is asserted the cycle after the master samples I_fb_ack.

Master transaction:
- Owner, address and data are latched at start.
- stb is held until I_fb_ack is sampled high, then dropped for at least 1 cycle.
- I_fb_ack is ignored while stb is low.
- Arbitration happens only when the master is idle. A pending CPU write wins over the fill engine, and the fill engine waits.

Fill FSM:
- IDLE: a CTRL start moves to SETUP. A start while not IDLE is ignored.
- SETUP: latch the extents, clipped per Configuration. Set row_base = Y0*160 (computed as shifts/adds), x=0, y=0, BUSY=1. If clipped W or H is 0, go to DONE.
- REQ: request a write of COLOR to row_base+X0+x. Wait for the grant and ack.
- ADV:
  - If x+1<W, increment x.
  - Otherwise set x=0, y=y+1, row_base += 160.
  - If y+1==H, go to DONE; otherwise return to REQ.
- DONE: BUSY=0, DONE=1, O_irq pulses 1 cycle, then go to IDLE.
- Write order is row-major, left to right, top to bottom.

Reset values:
- All outputs are 0.
- Registers are 0; BUSY=0 and DONE=0.
- The FSM is in IDLE.
- Assertion mid-fill or mid-transaction drops stb immediately and abandons the fill. No completion IRQ is issued.

## Timing
- Master transaction with the framebuffer's 1-cycle registered ack takes 3 cycles: stb high for 2, low for 1. The duplicate write is idempotent.
- Fill throughput is 1 pixel per 3 cycles when uncontended. A full screen is 57,600 cycles plus 2 cycles of SETUP/DONE.
- CPU pixel write latency (stb to O_wb_ack) with the master idle is 4 cycles. If a fill transaction is in flight, add up to 3 cycles.
- Register access latency is 1 cycle.

## Configuration
- WB_FB_FILL_CLIP_EN defined:
  - SETUP clamps W to min(W, FB_WIDTH−X0) and H to min(H, FB_HEIGHT−Y0).
  - X0≥FB_WIDTH or Y0≥FB_HEIGHT gives a zero-size fill.
- Undefined:
  - Extents are used raw and addresses wrap modulo 2^15.
  - The framebuffer drops addresses ≥19,200.

## Test plan
- Reset: assert I_rst_n=0 mid-fill → stb=0, ack=0 and irq=0 immediately; CTRL reads 0x00 after release.
- CPU write to pixel 0x12C5 with data 0xE0 → one master cycle with adr=0x12C5, dat=0xE0; O_wb_ack 4 cycles after stb.
- Fill X0=10, Y0=5, W=2, H=2, COLOR=0x1C → writes to 810, 811, 970, 971 in that order; one irq pulse; CTRL reads 0x02.
- With CLIP_EN, fill X0=158, Y0=119, W=10, H=5 → exactly 2 writes, to 19198 and 19199. W=0 → DONE with zero writes.
- Contention: CPU write issued during a fill → the CPU transaction is granted at the next idle slot ahead of the fill; no fill pixel is lost or duplicated.
- Start written while BUSY → ignored; the fill completes its original rectangle only.

Source files
------------

// File: rtl/wb_fb_fill_arbiter.sv
// Shares the framebuffer Wishbone write port between CPU pixel writes (fixed priority) and a rectangle-fill engine.
// Optional feature: define WB_FB_FILL_CLIP_EN to clamp fill rectangles to the framebuffer extents.
module wb_fb_fill_arbiter #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic        I_wb_clk,
  input  logic        I_rst_n,
  input  logic [15:0] I_wb_adr,
  input  logic [7:0]  I_wb_dat,
  input  logic        I_wb_we,
  input  logic        I_wb_stb,
  input  logic        I_wb_cyc,
  output logic        O_wb_ack,
  output logic [7:0]  O_wb_dat,
  output logic [14:0] O_fb_adr,
  output logic [7:0]  O_fb_dat,
  output logic        O_fb_we,
  output logic        O_fb_stb,
  output logic        O_fb_cyc,
  input  logic        I_fb_ack,
  output logic        O_irq
);

`ifdef WB_FB_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [14:0] ROW_STEP = 15'(FB_WIDTH);
  localparam logic [8:0]  FB_W9    = 9'(FB_WIDTH);
  localparam logic [8:0]  FB_H9    = 9'(FB_HEIGHT);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_ADV, S_DONE} fill_state_t;
  fill_state_t state, state_next;

  logic [7:0]  x0_r, y0_r, w_r, h_r, color_r;
  logic        busy_r, done_r;
  logic [7:0]  f_x0, f_w, f_h, f_color, x_cnt, y_cnt;
  logic [14:0] row_base;
  logic        cpu_pend;
  logic [14:0] cpu_adr;
  logic [7:0]  cpu_dat;
  logic        m_stb, m_owner_cpu;

  logic        req_valid, reg_sel, ctrl_wr, start_req, cpu_busy, pixel_wr;
  logic        m_ack, fill_grant, fill_ack, row_more, last_row;
  logic [2:0]  reg_off;
  logic [7:0]  rd_mux, clip_w, clip_h;
  logic [8:0]  room_x, room_y;
  logic [14:0] setup_base, fill_addr;

  assign req_valid  = I_wb_stb & I_wb_cyc & ~O_wb_ack;
  assign reg_sel    = I_wb_adr[15];
  assign reg_off    = I_wb_adr[2:0];
  assign ctrl_wr    = req_valid & reg_sel & I_wb_we & (reg_off == 3'd5);
  assign start_req  = ctrl_wr & I_wb_dat[0];
  assign cpu_busy   = cpu_pend | (m_stb & m_owner_cpu);
  assign pixel_wr   = req_valid & ~reg_sel & I_wb_we & ~cpu_busy;
  assign m_ack      = m_stb & I_fb_ack;
  assign fill_grant = ~m_stb & ~cpu_pend & (state == S_REQ);
  assign fill_ack   = m_ack & ~m_owner_cpu;

  assign O_fb_stb = m_stb;
  assign O_fb_cyc = m_stb;
  assign O_fb_we  = m_stb;

  // Constant multiply by the row pitch; reduces to shift-add logic.
  assign setup_base = {7'd0, y0_r} * ROW_STEP;
  assign fill_addr  = row_base + {7'd0, f_x0} + {7'd0, x_cnt};
  assign row_more   = ({1'b0, x_cnt} + 9'd1) < {1'b0, f_w};
  assign last_row   = ({1'b0, y_cnt} + 9'd1) == {1'b0, f_h};

  always_comb begin
    room_x = FB_W9 - {1'b0, x0_r};
    room_y = FB_H9 - {1'b0, y0_r};
    clip_w = w_r;
    clip_h = h_r;
    if (CLIP_EN) begin
      if ({1'b0, x0_r} >= FB_W9)       clip_w = 8'd0;
      else if ({1'b0, w_r} > room_x)   clip_w = room_x[7:0];
      if ({1'b0, y0_r} >= FB_H9)       clip_h = 8'd0;
      else if ({1'b0, h_r} > room_y)   clip_h = room_y[7:0];
    end
  end

  always_comb begin
    rd_mux = 8'd0;
    case (reg_off)
      3'd0:    rd_mux = x0_r;
      3'd1:    rd_mux = y0_r;
      3'd2:    rd_mux = w_r;
      3'd3:    rd_mux = h_r;
      3'd4:    rd_mux = color_r;
      3'd5:    rd_mux = {6'd0, done_r, busy_r};
      default: rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // REQ holds until the grant; ADV holds the pixel until the framebuffer acks it, then steps.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_req) state_next = S_SETUP;
      S_SETUP: state_next = (clip_w == 8'd0 || clip_h == 8'd0) ? S_DONE : S_REQ;
      S_REQ:   if (fill_grant) state_next = S_ADV;
      S_ADV:   if (fill_ack) state_next = (!row_more && last_row) ? S_DONE : S_REQ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      f_x0     <= 8'd0;
      f_w      <= 8'd0;
      f_h      <= 8'd0;
      f_color  <= 8'd0;
      x_cnt    <= 8'd0;
      y_cnt    <= 8'd0;
      row_base <= 15'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      O_irq    <= 1'b0;
    end else begin
      O_irq <= 1'b0;
      if (ctrl_wr && I_wb_dat[1]) done_r <= 1'b0;
      case (state)
        S_SETUP: begin
          f_x0     <= x0_r;
          f_color  <= color_r;
          f_w      <= clip_w;
          f_h      <= clip_h;
          row_base <= setup_base;
          x_cnt    <= 8'd0;
          y_cnt    <= 8'd0;
          busy_r   <= 1'b1;
        end
        S_ADV: begin
          if (fill_ack) begin
            if (row_more) begin
              x_cnt <= x_cnt + 8'd1;
            end else begin
              x_cnt    <= 8'd0;
              y_cnt    <= y_cnt + 8'd1;
              row_base <= row_base + ROW_STEP;
            end
          end
        end
        S_DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          O_irq  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      x0_r     <= 8'd0;
      y0_r     <= 8'd0;
      w_r      <= 8'd0;
      h_r      <= 8'd0;
      color_r  <= 8'd0;
      O_wb_ack <= 1'b0;
      O_wb_dat <= 8'd0;
    end else begin
      O_wb_ack <= 1'b0;
      O_wb_dat <= 8'd0;
      if (req_valid && reg_sel && I_wb_we) begin
        case (reg_off)
          3'd0:    x0_r    <= I_wb_dat;
          3'd1:    y0_r    <= I_wb_dat;
          3'd2:    w_r     <= I_wb_dat;
          3'd3:    h_r     <= I_wb_dat;
          3'd4:    color_r <= I_wb_dat;
          default: ;
        endcase
      end
      // Register accesses and pixel reads complete locally; pixel writes wait for the framebuffer.
      if (req_valid && (reg_sel || !I_wb_we)) begin
        O_wb_ack <= 1'b1;
        if (reg_sel && !I_wb_we) O_wb_dat <= rd_mux;
      end
      if (m_ack && m_owner_cpu) O_wb_ack <= 1'b1;
    end
  end

  // Master: arbitrates only while stb is low, so every transaction ends with at least one idle cycle.
  always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cpu_pend    <= 1'b0;
      cpu_adr     <= 15'd0;
      cpu_dat     <= 8'd0;
      m_stb       <= 1'b0;
      m_owner_cpu <= 1'b0;
      O_fb_adr    <= 15'd0;
      O_fb_dat    <= 8'd0;
    end else begin
      if (pixel_wr) begin
        cpu_pend <= 1'b1;
        cpu_adr  <= I_wb_adr[14:0];
        cpu_dat  <= I_wb_dat;
      end
      if (m_stb) begin
        if (I_fb_ack) m_stb <= 1'b0;
      end else if (cpu_pend) begin
        m_stb       <= 1'b1;
        m_owner_cpu <= 1'b1;
        O_fb_adr    <= cpu_adr;
        O_fb_dat    <= cpu_dat;
        cpu_pend    <= 1'b0;
      end else if (state == S_REQ) begin
        m_stb       <= 1'b1;
        m_owner_cpu <= 1'b0;
        O_fb_adr    <= fill_addr;
        O_fb_dat    <= f_color;
      end
    end
  end

endmodule

// File: tb/tb_wb_fb_fill_arbiter.sv
// Directed self-checking bench for wb_fb_fill_arbiter with a 1-cycle registered-ack framebuffer model.
// Clip-dependent expectations follow WB_FB_FILL_CLIP_EN.
module tb_wb_fb_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wb_adr;
  logic [7:0]  wb_dat_w;
  logic        wb_we, wb_stb, wb_cyc;
  logic        wb_ack;
  logic [7:0]  wb_dat_r;
  logic [14:0] fb_adr;
  logic [7:0]  fb_dat;
  logic        fb_we, fb_stb, fb_cyc;
  logic        fb_ack;
  logic        irq;

  logic [14:0] log_adr[$];
  logic [7:0]  log_dat[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          irq_cnt = 0;

  always #5 clk = ~clk;

  wb_fb_fill_arbiter #(.FB_WIDTH(160), .FB_HEIGHT(120)) dut (
    .I_wb_clk(clk),
    .I_rst_n (rst_n),
    .I_wb_adr(wb_adr),
    .I_wb_dat(wb_dat_w),
    .I_wb_we (wb_we),
    .I_wb_stb(wb_stb),
    .I_wb_cyc(wb_cyc),
    .O_wb_ack(wb_ack),
    .O_wb_dat(wb_dat_r),
    .O_fb_adr(fb_adr),
    .O_fb_dat(fb_dat),
    .O_fb_we (fb_we),
    .O_fb_stb(fb_stb),
    .O_fb_cyc(fb_cyc),
    .I_fb_ack(fb_ack),
    .O_irq   (irq)
  );

  // Framebuffer slave: one registered ack per strobe, each completed write logged once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fb_ack <= 1'b0;
    else        fb_ack <= fb_stb & ~fb_ack;
  end

  always @(posedge clk) begin
    if (rst_n && fb_stb && fb_cyc && fb_we && fb_ack) begin
      log_adr.push_back(fb_adr);
      log_dat.push_back(fb_dat);
    end
    if (irq) irq_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One CPU Wishbone cycle; lat counts clock edges from stb until ack is seen.
  task automatic applyStimulus(input logic [15:0] adr, input logic [7:0] dat, input logic we,
                               output logic [7:0] rdat, output int lat);
    wb_adr   = adr;
    wb_dat_w = dat;
    wb_we    = we;
    wb_stb   = 1'b1;
    wb_cyc   = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!wb_ack && lat < 200);
    if (!wb_ack) checkOutput("wb_ack_timeout", {31'd0, wb_ack}, 32'd1);
    rdat   = wb_dat_r;
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic regWrite(input logic [2:0] off, input logic [7:0] dat);
    logic [7:0] unused_rd;
    int         unused_lat;
    applyStimulus({13'h1000, off}, dat, 1'b1, unused_rd, unused_lat);
  endtask

  task automatic regRead(input logic [2:0] off, output logic [7:0] dat);
    int lat;
    applyStimulus({13'h1000, off}, 8'h00, 1'b0, dat, lat);
  endtask

  task automatic startFill(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                           input logic [7:0] h, input logic [7:0] color);
    regWrite(3'd0, x0);
    regWrite(3'd1, y0);
    regWrite(3'd2, w);
    regWrite(3'd3, h);
    regWrite(3'd4, color);
    regWrite(3'd5, 8'h03);
  endtask

  task automatic waitIrq(input string tag, input int target);
    int i = 0;
    while (irq_cnt < target && i < 3000) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput(tag, irq_cnt, target);
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    int         irq_base;
    int         log_base;

    rst_n = 1'b0; wb_adr = 16'h0; wb_dat_w = 8'h0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_fb_stb", {31'd0, fb_stb}, 32'd0);
    checkOutput("reset_wb_ack", {31'd0, wb_ack}, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("reset_fb_adr", {17'd0, fb_adr}, 32'd0);
    checkOutput("reset_wb_dat", {24'd0, wb_dat_r}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] register window");
    applyStimulus(16'h8005, 8'h00, 1'b0, rd, lat);
    checkOutput("ctrl_after_reset", {24'd0, rd}, 32'h00);
    checkOutput("reg_read_latency", lat, 1);
    regWrite(3'd0, 8'h5A);
    regRead(3'd0, rd);
    checkOutput("x0_readback", {24'd0, rd}, 32'h5A);
    regWrite(3'd6, 8'hFF);
    regRead(3'd6, rd);
    checkOutput("reg6_reads_zero", {24'd0, rd}, 32'h00);
    checkOutput("reg_no_master", log_adr.size(), 0);

    $display("[TB] cpu pixel access");
    applyStimulus(16'h12C5, 8'hE0, 1'b1, rd, lat);
    checkOutput("cpu_wr_latency", lat, 4);
    checkOutput("cpu_wr_count", log_adr.size(), 1);
    checkOutput("cpu_wr_adr", {17'd0, log_adr[0]}, 32'h12C5);
    checkOutput("cpu_wr_dat", {24'd0, log_dat[0]}, 32'hE0);
    applyStimulus(16'h0005, 8'h00, 1'b0, rd, lat);
    checkOutput("pixel_read_dat", {24'd0, rd}, 32'h00);
    checkOutput("pixel_read_latency", lat, 1);

    $display("[TB] basic fill");
    log_adr.delete(); log_dat.delete();
    irq_base = irq_cnt;
    startFill(8'd10, 8'd5, 8'd2, 8'd2, 8'h1C);
    waitIrq("fill_irq", irq_base + 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("fill_irq_once", irq_cnt, irq_base + 1);
    checkOutput("fill_count", log_adr.size(), 4);
    checkOutput("fill_adr0", {17'd0, log_adr[0]}, 32'd810);
    checkOutput("fill_adr1", {17'd0, log_adr[1]}, 32'd811);
    checkOutput("fill_adr2", {17'd0, log_adr[2]}, 32'd970);
    checkOutput("fill_adr3", {17'd0, log_adr[3]}, 32'd971);
    checkOutput("fill_dat0", {24'd0, log_dat[0]}, 32'h1C);
    checkOutput("fill_dat3", {24'd0, log_dat[3]}, 32'h1C);
    regRead(3'd5, rd);
    checkOutput("ctrl_done", {24'd0, rd}, 32'h02);
    regWrite(3'd5, 8'h02);
    regRead(3'd5, rd);
    checkOutput("ctrl_done_cleared", {24'd0, rd}, 32'h00);

    $display("[TB] edge-of-screen fill");
    log_adr.delete(); log_dat.delete();
    irq_base = irq_cnt;
`ifdef WB_FB_FILL_CLIP_EN
    startFill(8'd158, 8'd119, 8'd10, 8'd5, 8'h42);
    waitIrq("edge_irq", irq_base + 1);
    checkOutput("edge_count", log_adr.size(), 2);
    checkOutput("edge_adr0", {17'd0, log_adr[0]}, 32'd19198);
    checkOutput("edge_adr1", {17'd0, log_adr[1]}, 32'd19199);
`else
    startFill(8'd158, 8'd119, 8'd3, 8'd1, 8'h42);
    waitIrq("edge_irq", irq_base + 1);
    checkOutput("edge_count", log_adr.size(), 3);
    checkOutput("edge_adr0", {17'd0, log_adr[0]}, 32'd19198);
    checkOutput("edge_adr1", {17'd0, log_adr[1]}, 32'd19199);
    checkOutput("edge_adr2", {17'd0, log_adr[2]}, 32'd19200);
`endif

    $display("[TB] zero-width fill");
    log_adr.delete(); log_dat.delete();
    irq_base = irq_cnt;
    startFill(8'd1, 8'd1, 8'd0, 8'd3, 8'h11);
    waitIrq("zero_irq", irq_base + 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("zero_count", log_adr.size(), 0);
    regRead(3'd5, rd);
    checkOutput("zero_ctrl", {24'd0, rd}, 32'h02);

    $display("[TB] start while busy");
    log_adr.delete(); log_dat.delete();
    irq_base = irq_cnt;
    startFill(8'd0, 8'd0, 8'd4, 8'd1, 8'h33);
    regWrite(3'd0, 8'd50);
    regWrite(3'd4, 8'hCC);
    regWrite(3'd5, 8'h01);
    regRead(3'd5, rd);
    checkOutput("ctrl_busy", {24'd0, rd}, 32'h01);
    waitIrq("busy_irq", irq_base + 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy_irq_once", irq_cnt, irq_base + 1);
    checkOutput("busy_count", log_adr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("busy_adr%0d", i), {17'd0, log_adr[i]}, i);
      checkOutput($sformatf("busy_dat%0d", i), {24'd0, log_dat[i]}, 32'h33);
    end

    $display("[TB] cpu write during fill");
    log_adr.delete(); log_dat.delete();
    irq_base = irq_cnt;
    startFill(8'd0, 8'd1, 8'd3, 8'd1, 8'h55);
    applyStimulus(16'h0100, 8'hAA, 1'b1, rd, lat);
    checkOutput("contend_latency_bound", {31'd0, lat <= 7}, 32'd1);
    waitIrq("contend_irq", irq_base + 1);
    checkOutput("contend_count", log_adr.size(), 4);
    checkOutput("contend_adr0", {17'd0, log_adr[0]}, 32'd160);
    checkOutput("contend_adr1", {17'd0, log_adr[1]}, 32'h0100);
    checkOutput("contend_dat1", {24'd0, log_dat[1]}, 32'hAA);
    checkOutput("contend_adr2", {17'd0, log_adr[2]}, 32'd161);
    checkOutput("contend_adr3", {17'd0, log_adr[3]}, 32'd162);
    checkOutput("contend_dat3", {24'd0, log_dat[3]}, 32'h55);

    $display("[TB] reset mid-fill");
    irq_base = irq_cnt;
    startFill(8'd0, 8'd0, 8'd20, 8'd20, 8'h77);
    for (int i = 0; i < 100 && !fb_stb; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midfill_stb_seen", {31'd0, fb_stb}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midfill_rst_stb", {31'd0, fb_stb}, 32'd0);
    checkOutput("midfill_rst_ack", {31'd0, wb_ack}, 32'd0);
    checkOutput("midfill_rst_irq", {31'd0, irq}, 32'd0);
    log_base = log_adr.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midfill_no_irq", irq_cnt, irq_base);
    checkOutput("midfill_no_writes", log_adr.size(), log_base);
    regRead(3'd5, rd);
    checkOutput("midfill_ctrl", {24'd0, rd}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
